multi_cycle_cpu: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS-subset core. It executes the same R-type/immediate/branch instruction subset, adds `lw`/`sw`, and runs a control FSM over a single shared memory port with a request/ready handshake, so instruction and data memories can have wait states. It sits at the top of the CPU hierarchy and is the unit that the system memory model or bus bridge connects to.

---
 rtl/multi_cycle_cpu_if.sv | 23 ++
 rtl/multi_cycle_cpu.sv | 218 +++++++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_cpu_if.sv
// Shared instruction/data memory port of multi_cycle_cpu: request/ready handshake,
// one access in flight, address and data held stable until ready.
interface multi_cycle_cpu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) on one shared memory port.
// Define CPU_JUMP_EN to add j/jal; without it ops 02/03 decode as illegal.
module multi_cycle_cpu #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multi_cycle_cpu_if.master mem,
    output logic              retire_o,
    output logic              illegal_o,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef CPU_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
`endif

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] regs [32];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm_sext;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    logic legal;
    logic is_branch;
    logic is_jump;
    logic is_mem_op;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_LW, OP_SW: legal = 1'b1;
`ifdef CPU_JUMP_EN
            OP_J, OP_JAL: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_mem_op = (op == OP_LW) || (op == OP_SW);
`ifdef CPU_JUMP_EN
    assign is_jump   = (op == OP_J) || (op == OP_JAL);

    logic [31:0] pc_ext;
    logic [31:0] jump_addr;
    // Upper PC bits come from the already-incremented PC; narrow PCs simply truncate.
    assign pc_ext    = 32'(pc);
    assign jump_addr = {pc_ext[31:28], ir[25:0], 2'b00};
`else
    assign is_jump   = 1'b0;
`endif

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              lt;
    logic              taken;

    always_comb begin
        alu_b   = (op == OP_RTYPE) ? b : imm_sext;
        lt      = $signed(a) < $signed(alu_b);
        alu_res = a + alu_b;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_res = a - b;
                F_AND:   alu_res = a & b;
                F_OR:    alu_res = a | b;
                F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, lt};
                default: alu_res = a + b;
            endcase
        end else if (op == OP_SLTI) begin
            alu_res = {{(DATA_W-1){1'b0}}, lt};
        end
    end

    assign taken = (op == OP_BEQ) ? (a == b) : (a != b);

    logic [4:0]        wb_idx;
    logic [DATA_W-1:0] wb_data;

    assign wb_idx  = (op == OP_RTYPE) ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr : alu_out;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_FETCH;
            pc      <= RESET_PC[ADDR_W-1:0];
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            // NOTE: the register file is architecturally cleared on reset, so it is
            // built from flops rather than a RAM macro without a reset path.
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem.mem_ready_i) begin
                        ir    <= mem.mem_rdata_i[31:0];
                        pc    <= pc + ADDR_W'(4);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= DATA_W'(pc) + (imm_sext << 2);
                    if (!legal) begin
                        state <= S_FETCH;
                    end
`ifdef CPU_JUMP_EN
                    else if (is_jump) begin
                        pc <= jump_addr[ADDR_W-1:0];
                        if (op == OP_JAL) begin
                            regs[31] <= DATA_W'(pc);
                        end
                        state <= S_FETCH;
                    end
`endif
                    else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        if (taken) begin
                            pc <= alu_out[ADDR_W-1:0];
                        end
                        state <= S_FETCH;
                    end else begin
                        alu_out <= alu_res;
                        state   <= is_mem_op ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ready_i) begin
                        if (op == OP_LW) begin
                            mdr   <= mem.mem_rdata_i;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) begin
                        regs[wb_idx] <= wb_data;
                    end
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Request and pulses are decoded from registered state but gated by rst_i,
    // so a reset withdraws an in-flight access within the same cycle.
    assign mem.mem_req_o   = !rst_i && (state == S_FETCH || state == S_MEM);
    assign mem.mem_we_o    = !rst_i && (state == S_MEM) && (op == OP_SW);
    assign mem.mem_addr_o  = (state == S_MEM) ? {alu_out[ADDR_W-1:2], 2'b00} : pc;
    assign mem.mem_wdata_o = b;

    assign retire_o  = !rst_i && (((state == S_DECODE) && (!legal || is_jump)) ||
                                  ((state == S_EXEC) && is_branch) ||
                                  ((state == S_MEM) && (op == OP_SW) && mem.mem_ready_i) ||
                                  (state == S_WB));
    assign illegal_o = !rst_i && (state == S_DECODE) && !legal;
    assign pc_o      = pc;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: an instruction-level reference model drives
// expected fetch/store traffic, cycle counts and PC; memory adds directed/random wait states.
module tb_multi_cycle_cpu;
    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              retire;
    logic              illegal;
    logic [ADDR_W-1:0] pc;

    always #5 clk = ~clk;

    multi_cycle_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    multi_cycle_cpu #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .mem      (bus),
        .retire_o (retire),
        .illegal_o(illegal),
        .pc_o     (pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // bus_mem is what the DUT sees; ref_mem belongs to the reference model.
    logic [31:0] bus_mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_r   [32];
    logic [31:0] ref_pc;

    function automatic int idx(input logic [31:0] addr);
        return int'(addr[11:2]);
    endfunction

    function automatic logic [31:0] r_op(input int f, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(f)};
    endfunction

    function automatic logic [31:0] i_op(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        bus_mem[idx(addr)] = word;
        ref_mem[idx(addr)] = word;
    endtask

    // Executes one instruction of the architectural model and reports what the bus should show.
    task automatic ref_step(output int base, output bit has_data, output bit exp_we,
                            output logic [31:0] exp_addr, output logic [31:0] exp_wdata,
                            output bit is_ill);
        logic [31:0] ins, npc, simm, va, vb, res;
        logic [5:0]  op, fn;
        int          rs, rt, rd, dst;
        ins  = ref_mem[idx(ref_pc)];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        simm = {{16{ins[15]}}, ins[15:0]};
        va   = ref_r[rs];
        vb   = ref_r[rt];
        npc  = ref_pc + 32'd4;
        base = 4; has_data = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; is_ill = 0;
        dst  = 0; res = '0;
        case (op)
            6'h00: begin
                dst = rd;
                case (fn)
                    6'h20: res = va + vb;
                    6'h22: res = va - vb;
                    6'h24: res = va & vb;
                    6'h25: res = va | vb;
                    6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                    default: begin is_ill = 1; dst = 0; end
                endcase
            end
            6'h08: begin dst = rt; res = va + simm; end
            6'h0A: begin dst = rt; res = ($signed(va) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h04: begin base = 3; if (va == vb) npc = npc + (simm << 2); end
            6'h05: begin base = 3; if (va != vb) npc = npc + (simm << 2); end
            6'h23: begin
                base = 5; has_data = 1;
                exp_addr = (va + simm) & ~32'h3;
                dst = rt; res = ref_mem[idx(exp_addr)];
            end
            6'h2B: begin
                has_data = 1; exp_we = 1;
                exp_addr = (va + simm) & ~32'h3;
                exp_wdata = vb;
                ref_mem[idx(exp_addr)] = vb;
            end
`ifdef CPU_JUMP_EN
            6'h02, 6'h03: begin
                base = 2;
                if (op == 6'h03) begin dst = 31; res = npc; end
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
`endif
            default: is_ill = 1;
        endcase
        if (is_ill) base = 2;
        if (dst != 0) ref_r[dst] = res;
        ref_pc = npc;
    endtask

    // Runs one instruction on the DUT, acting as memory with wf fetch / wd data wait cycles.
    task automatic exec_one(input int wf, input int wd);
        int          base, exp_cyc, cyc, waited, need;
        bit          has_data, exp_we, is_ill, fetched, retired;
        logic [31:0] exp_addr, exp_wdata, pc0, h_addr, h_wd;
        logic        h_we;
        pc0 = ref_pc;
        ref_step(base, has_data, exp_we, exp_addr, exp_wdata, is_ill);
        exp_cyc = base + wf + (has_data ? wd : 0);
        cyc = 0; waited = 0; fetched = 0; retired = 0;
        h_addr = '0; h_wd = '0; h_we = 1'b0;
        while (!retired && cyc < 64) begin
            @(negedge clk);
            cyc++;
            bus.mem_ready_i = 1'b0;
            if (bus.mem_req_o) begin
                if (waited == 0) begin
                    h_addr = bus.mem_addr_o; h_we = bus.mem_we_o; h_wd = bus.mem_wdata_o;
                    if (!fetched) begin
                        check("fetch_addr", bus.mem_addr_o, pc0);
                        check("fetch_we", bus.mem_we_o, 0);
                    end else begin
                        check("data_access_expected", has_data, 1);
                        check("data_addr", bus.mem_addr_o, exp_addr);
                        check("data_we", bus.mem_we_o, exp_we);
                        if (exp_we) check("store_data", bus.mem_wdata_o, exp_wdata);
                    end
                end else begin
                    check("hold_addr", bus.mem_addr_o, h_addr);
                    check("hold_we", bus.mem_we_o, h_we);
                    check("hold_wdata", bus.mem_wdata_o, h_wd);
                end
                need = fetched ? wd : wf;
                if (waited >= need) begin
                    bus.mem_rdata_i = bus_mem[idx(bus.mem_addr_o)];
                    if (bus.mem_we_o) bus_mem[idx(bus.mem_addr_o)] = bus.mem_wdata_o;
                    bus.mem_ready_i = 1'b1;
                    waited  = 0;
                    fetched = 1;
                end else begin
                    waited++;
                end
            end else begin
                bus.mem_ready_i = 1'($urandom_range(0, 1));
            end
            #1;
            if (retire) begin
                retired = 1;
                check("cycles", cyc, exp_cyc);
                check("illegal", illegal, is_ill);
            end
        end
        check("retired", retired, 1);
        @(posedge clk);
        #1;
        check("pc", pc, ref_pc);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.mem_ready_i = 1'b1;
            check("req_in_reset", bus.mem_req_o, 0);
            check("retire_in_reset", retire, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready_i = 1'b0;
        ref_pc = RESET_PC;
        for (int r = 0; r < 32; r++) ref_r[r] = '0;
        #1;
        check("first_req", bus.mem_req_o, 1);
        check("first_addr", bus.mem_addr_o, RESET_PC);
        check("first_we", bus.mem_we_o, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        int          k    = $urandom_range(0, 9);
        int          ra   = $urandom_range(0, 31);
        int          rb   = $urandom_range(0, 31);
        int          rc   = $urandom_range(0, 31);
        int          base = ($urandom_range(0, 3) == 0) ? rb : 0;
        logic [5:0]  fn;
        case (k)
            0, 1, 2: begin
                case ($urandom_range(0, 5))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    4: fn = 6'h2A;
                    default: fn = 6'h21;
                endcase
                return r_op(int'(fn), ra, rb, rc);
            end
            3: return i_op(8, ra, rb, int'($urandom_range(0, 65535)));
            4: return i_op('h0A, ra, rb, int'($urandom_range(0, 65535)));
            5: return i_op(int'($urandom_range(4, 5)), ra, ($urandom_range(0, 1) != 0) ? ra : rb,
                           int'($urandom_range(0, 4)));
            6: return i_op('h23, ra, base, 'h800 + int'($urandom_range(0, 1023)));
            7: return i_op('h2B, ra, base, 'h800 + int'($urandom_range(0, 1023)));
            8: return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom_range('h40, 'h17F))};
            default: return {($urandom_range(0, 1) != 0) ? 6'h3F : 6'h10, 26'($urandom)};
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          beq_hits;
        int          guard;
        int          wt;
        bit          seen;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        for (int i = 0; i < 1024; i++) begin
            bus_mem[i] = '0;
            ref_mem[i] = '0;
        end

        put(32'h100, i_op(8, 1, 0, 5));
        put(32'h104, i_op(8, 2, 0, -3));
        put(32'h108, r_op('h20, 3, 1, 2));
        put(32'h10C, r_op('h2A, 4, 2, 1));
        put(32'h110, i_op('h2B, 4, 0, 'h804));
        put(32'h114, i_op('h2B, 3, 0, 8));
        put(32'h118, i_op('h23, 5, 0, 8));
        put(32'h11C, i_op('h2B, 5, 0, 'h808));
        put(32'h120, i_op(4, 1, 1, -1));
        put(32'h124, 32'hFC00_0000);
        put(32'h128, i_op(8, 0, 0, 7));
        put(32'h12C, i_op('h2B, 0, 0, 'h80C));
        put(32'h130, i_op(4, 0, 0, -61));
        put(32'h040, {6'h03, 26'h80});
        put(32'h044, i_op('h2B, 31, 0, 'h810));
        put(32'h048, i_op(4, 0, 0, 109));
        put(32'h200, i_op('h2B, 31, 0, 'h810));
        put(32'h204, i_op('h2B, 3, 0, 'h814));

        do_reset(3);

        beq_hits = 0;
        guard    = 0;
        while (ref_pc != 32'h204 && guard < 40) begin
            guard++;
            if (ref_pc == 32'h120) begin
                beq_hits++;
                if (beq_hits == 4) put(32'h120, i_op(5, 0, 0, 4));
            end
            wt = (ref_pc == 32'h114 || ref_pc == 32'h118) ? 2 : 0;
            exec_one(wt, wt);
        end

        // Reset while the store at 0x204 is stalled in its data phase.
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            bus.mem_ready_i = bus.mem_req_o && !bus.mem_we_o;
            bus.mem_rdata_i = bus_mem[idx(bus.mem_addr_o)];
            if (bus.mem_req_o && bus.mem_we_o) begin
                seen = 1;
                bus.mem_ready_i = 1'b0;
            end
        end
        check("store_reached_mem", seen, 1);
        rst = 1'b1;
        #1;
        check("reset_drops_req", bus.mem_req_o, 0);
        do_reset(2);

        for (int a = 32'h100; a < 32'h600; a += 4) put(32'(a), rand_instr());
        for (int n = 0; n < 300; n++) begin
            exec_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        for (int r = 1; r < 32; r++) begin
            put(ref_pc, i_op('h2B, r, 0, 'hC00 + 4 * r));
            exec_one(0, int'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
